// File: rtl/serial_en_tx.sv
// serial_en_tx: parallel-in, serial-out transmitter with an enable qualifier.
// The word is accepted over load/ready and sent MSB first, one bit per clock.
// An even-parity bit is appended when the macro SERIAL_EN_TX_PARITY_EN is defined.
// IDLE_GAP cycles with en_out low follow each word. At least one IDLE cycle
// (ready high) always separates two consecutive words.
module serial_en_tx #(
   parameter int WIDTH    = 8,
   parameter int IDLE_GAP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             d_out,
   output logic             en_out,
   output logic             last,
   output logic             busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_GAP    = 2'd3;

   // The counter serves both the bit index (max 31) and the gap length (max 14).
   localparam int CW = 6;

   // After the final enabled bit, skip GAP entirely when no gap is configured.
   localparam logic [1:0] S_AFTER = (IDLE_GAP == 0) ? S_IDLE : S_GAP;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   // Holds the bits still to be sent. Its MSB is the next bit to drive.
   logic [WIDTH-1:0] sr;
`ifdef SERIAL_EN_TX_PARITY_EN
   logic             par;
`endif

   // ready and busy are decoded from the state register only.
   assign ready = (state == S_IDLE);
   assign busy  = ~ready;

   // Main FSM. All outputs are registered alongside the state, so each output
   // value describes the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sr     <= '0;
         d_out  <= 1'b0;
         en_out <= 1'b0;
         last   <= 1'b0;
`ifdef SERIAL_EN_TX_PARITY_EN
         par    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               d_out  <= 1'b0;
               en_out <= 1'b0;
               last   <= 1'b0;
               if (load) begin
                  // The MSB goes out immediately. The remaining bits wait left-aligned in sr.
                  sr     <= {data_in[WIDTH-2:0], 1'b0};
                  cnt    <= '0;
                  state  <= S_SHIFT;
                  d_out  <= data_in[WIDTH-1];
                  en_out <= 1'b1;
`ifdef SERIAL_EN_TX_PARITY_EN
                  par    <= ^data_in;
`endif
               end
            end
            S_SHIFT: begin
               if (cnt == CW'(WIDTH - 1)) begin
                  cnt <= '0;
`ifdef SERIAL_EN_TX_PARITY_EN
                  state  <= S_PARITY;
                  d_out  <= par;
                  en_out <= 1'b1;
                  last   <= 1'b1;
`else
                  state  <= S_AFTER;
                  d_out  <= 1'b0;
                  en_out <= 1'b0;
                  last   <= 1'b0;
`endif
               end else begin
                  cnt    <= cnt + 1'b1;
                  sr     <= {sr[WIDTH-2:0], 1'b0};
                  d_out  <= sr[WIDTH-1];
                  en_out <= 1'b1;
`ifdef SERIAL_EN_TX_PARITY_EN
                  last   <= 1'b0;
`else
                  last   <= (cnt == CW'(WIDTH - 2));
`endif
               end
            end
`ifdef SERIAL_EN_TX_PARITY_EN
            S_PARITY: begin
               state  <= S_AFTER;
               cnt    <= '0;
               d_out  <= 1'b0;
               en_out <= 1'b0;
               last   <= 1'b0;
            end
`endif
            S_GAP: begin
               d_out  <= 1'b0;
               en_out <= 1'b0;
               last   <= 1'b0;
               if (cnt == CW'(IDLE_GAP - 1)) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               cnt    <= '0;
               d_out  <= 1'b0;
               en_out <= 1'b0;
               last   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_en_tx.md
# serial_en_tx

- Parallel-in, serial-out transmitter that drives a bit-serial data line `d_out` and a per-bit qualifier `en_out`.
- Downstream capture uses enable-gated flops: a flop samples `d_out` only on clock edges where `en_out` is high.
- It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per clock.
- It can append an even-parity bit, then inserts a programmable idle gap before accepting the next word.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits. Legal range 2..32.
- `IDLE_GAP`, default 1: number of gap cycles with `en_out` low after each word. Legal range 0..15.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `data_in`  input  WIDTH: word to send; sampled only on the accept edge.
- `load`  input  1: word valid.
- `ready`  output  1: high exactly when in IDLE. Decoded from the state register.
- `d_out`  output  1: serial data bit, registered.
- `en_out`  output  1: high in every cycle in which `d_out` carries a valid bit, registered.
- `last`  output  1: high with the final bit of a word, registered.
- `busy`  output  1: high in SHIFT, PARITY and GAP.

## Operation
- States: IDLE, SHIFT, PARITY, GAP.
- **Accept:** on a rising edge where `load && ready`.
  - Latch `data_in` into the shift register.
  - Clear the bit counter.
  - Go to SHIFT.
- **Load while not ready:** ignored, not queued. `data_in` changes after accept have no effect.
- **SHIFT:** one bit per cycle, MSB first.
  - `d_out` = current MSB of the shift register; `en_out` = 1.
  - The counter runs 0..WIDTH-1.
  - After bit WIDTH-1, go to PARITY if the parity macro is defined; otherwise go to GAP, or to IDLE when IDLE_GAP = 0.
- **PARITY:** one cycle.
  - `d_out` = XOR of all WIDTH latched bits (even parity); `en_out` = 1.
  - Then go to GAP, or to IDLE when IDLE_GAP = 0.
- **GAP:** IDLE_GAP cycles with `en_out` = 0 and `d_out` = 0; then go to IDLE.
- **IDLE:** `en_out` = 0, `d_out` = 0, `last` = 0, `ready` = 1.
- **`last`:** high only on the final bit of a word with `en_out` = 1. That is the data bit WIDTH-1, or the parity bit when parity is compiled in.
- **Reset values:** `d_out` = 0, `en_out` = 0, `last` = 0, `busy` = 0, `ready` = 1, state IDLE, counter 0.
- **Reset mid-word:** all outputs return to their reset values immediately (asynchronous). The word in flight is discarded; there is no resume.

## Timing
- **Latency:** accept at edge N → first bit (the MSB) valid on `d_out`/`en_out` in the cycle after edge N.
- **Frame length** with P = 1 if parity is compiled in, else 0:
  - `en_out` is high for WIDTH+P consecutive cycles.
  - Then low for IDLE_GAP cycles.
  - Then `ready` is high for at least one IDLE cycle.
- **Throughput:** with `load` held high, one word every WIDTH+P+IDLE_GAP+1 cycles.
- **Back-to-back accepts:** `en_out` is never high in two adjacent words without at least one low cycle (the IDLE cycle), even when IDLE_GAP = 0.
- `ready` falls in the cycle after accept.
- `busy` is the exact complement of `ready`.
- **Sampling:** all outputs are stable for the whole cycle. A receiver sampling `d_out` on the next rising edge when `en_out` = 1 reconstructs the word exactly.

## Configuration
- Macro `SERIAL_EN_TX_PARITY_EN`.
- **Defined:**
  - The PARITY state exists.
  - Each word is WIDTH+1 enabled bits, with the even-parity bit last.
  - `last` marks the parity bit.
- **Undefined:**
  - There is no PARITY state or parity logic.
  - Each word is WIDTH enabled bits.
  - `last` marks data bit WIDTH-1.

## Test plan
All scenarios use WIDTH=8, IDLE_GAP=1.

- **Reset:** assert `rst_n` = 0 mid-simulation → `d_out`/`en_out`/`last`/`busy` = 0 and `ready` = 1 within the same cycle, with no clock edge needed.
- **Single word, parity off:** load `8'hA5` → `en_out` high 8 cycles with `d_out` = 1,0,1,0,0,1,0,1 and `last` on the 8th bit. Then 1 gap cycle, then `ready` = 1.
- **Parity on:** load `8'h07` → 8 data bits then parity bit 1, with `last` on the parity bit. Load `8'h03` → parity bit 0.
- **Back-to-back:** `load` held high with `8'hFF` then `8'h00` → accept period of 10 cycles without parity and 11 with parity. Second word is `8'h00`, with `en_out` low between words.
- **Load while busy:** pulse `load` with `8'h3C` during SHIFT of `8'hA5` → pulse ignored. The transmitted stream is `8'hA5` only, and `data_in` changes during SHIFT do not alter it.
- **Reset mid-word:** drop `rst_n` after 4 bits of `8'hF0`, release, then load `8'h81` → no further bits of `8'hF0` appear. `8'h81` is transmitted cleanly, starting in the cycle after its accept.
